scoreboard: RTL and testbench
=============================

SCOREBOARD -- requirements
Module: scoreboard

Interface
REQ-001 Parameter NUM_REGS, default 32, number of architectural registers; register 0 is hard-wired zero.
REQ-002 Parameter REG_SIZE, default 5, register address width; SHALL satisfy 2**REG_SIZE >= NUM_REGS.
REQ-003 Parameter MAX_LAT, default 4, maximum result latency in cycles; LAT_W = clog2(MAX_LAT+1).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 issue_valid  input  1  decode presents an instruction this cycle.
REQ-007 issue_we  input  1  instruction writes a destination register.
REQ-008 issue_rd  input  REG_SIZE  destination register.
REQ-009 issue_lat  input  LAT_W  cycles until the result is forwardable (0 = next cycle).
REQ-010 issue_rs1, issue_rs2  input  REG_SIZE  source registers.
REQ-011 flush  input  1  squash the instruction presented this cycle.
REQ-012 wb_valid  input  1  a register write retires this cycle.
REQ-013 wb_rd  input  REG_SIZE  retiring destination register.
REQ-014 stall  output  1  hold fetch/decode; issue not accepted.
REQ-015 fwd1_ready, fwd2_ready  output  1  source value must be taken from the bypass network, not the register file.
REQ-016 busy_vec  output  NUM_REGS  per-register pending-write bits.
REQ-017 pending_cnt  output  clog2(NUM_REGS+1)  number of set busy bits.

Function
REQ-018 Per register r: busy[r] (1 bit) and cnt[r] (LAT_W bits); busy[0] and cnt[0] SHALL stay 0 permanently.
REQ-019 Source s (s != 0) is RAW-blocked when busy[s] && cnt[s] != 0; it is forwardable when busy[s] && cnt[s] == 0.
REQ-020 WAW block: issue_we && issue_rd != 0 && busy[issue_rd] && cnt[issue_rd] >= issue_lat (after saturation).
REQ-021 stall = issue_valid && !flush && (RAW-blocked rs1 || RAW-blocked rs2 || WAW block); combinational, no registered delay.
REQ-022 fwdN_ready = issue_valid && source N forwardable; combinational; 0 for source register 0.
REQ-023 Issue accepted when issue_valid && !stall && !flush; if also issue_we && issue_rd != 0, next cycle busy[rd]=1 and cnt[rd]=issue_lat.
REQ-024 issue_lat > MAX_LAT SHALL saturate to MAX_LAT.
REQ-025 Every cycle, each cnt[r] != 0 not being loaded by an issue SHALL decrement by 1; cnt SHALL never wrap below 0.
REQ-026 wb_valid with wb_rd != 0 clears busy[wb_rd] and cnt[wb_rd] next cycle.
REQ-027 Same-cycle accepted issue and writeback to the same register: issue wins (busy=1, cnt=issue_lat).
REQ-028 Writeback to a non-busy register or to register 0 SHALL be ignored without error.
REQ-029 flush squashes only the current issue; existing busy/cnt state continues to evolve; stall is forced 0 while flush=1.
REQ-030 pending_cnt = popcount(busy_vec), registered view consistent with busy_vec in the same cycle.

Reset
REQ-031 reset low SHALL immediately clear all busy and cnt; busy_vec=0, pending_cnt=0, stall=0, fwd1_ready=0, fwd2_ready=0 regardless of clock.
REQ-032 Reset asserted mid-operation discards all pending entries; later wb_valid for those registers falls under REQ-028.
REQ-033 First issue SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-034 NUM_REGS, REG_SIZE and MAX_LAT defaults SHALL live in consts.v next to WORD and REG_SIZE.
REQ-035 One sub-module sb_entry (busy bit + countdown, load/clear/decrement) SHALL be instantiated per register 1..NUM_REGS-1 via generate.
REQ-036 The hazard unit consumes stall/fwdN_ready; the scoreboard holds no data values.

Verification
REQ-037 Issue x5 lat=2, then rs1=x5 each following cycle -> stall=1 for 2 cycles, then stall=0 and fwd1_ready=1.
REQ-038 Issue x7 lat=3, next cycle issue rd=x7 lat=1 -> WAW stall until cnt[7] < 1, then accepted with cnt[7]=1.
REQ-039 wb_valid x9 and accepted issue rd=x9 lat=4 in the same cycle -> busy[9]=1, cnt[9]=4, pending_cnt unchanged.
REQ-040 Issue rd=x0 lat=4, then rs1=x0 -> busy_vec=0, stall=0, fwd1_ready=0.
REQ-041 Issue x3 lat=7 with MAX_LAT=4 -> cnt[3]=4; flush with a RAW-blocked issue -> stall=0, state unchanged.
REQ-042 Three registers busy, reset pulsed low between clock edges -> busy_vec=0 and pending_cnt=0 before the next edge.

Source files
------------

// File: rtl/scoreboard_pkg.sv
// Shared constants for the register scoreboard.
// Holds core-wide word and register-file sizing defaults.
package scoreboard_pkg;

   localparam int WORD         = 32;
   localparam int DEF_NUM_REGS = 32;
   localparam int DEF_REG_SIZE = 5;
   localparam int DEF_MAX_LAT  = 4;

endpackage

// File: rtl/scoreboard_sb_entry.sv
// One scoreboard entry: pending-write bit plus latency countdown.
// Ports: clk, reset (async low), load/loadLat, clear -> busy, cnt.
module sb_entry #(
   parameter int LAT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [LAT_W-1:0] loadLat,
   input  logic             clear,
   output logic             busy,
   output logic [LAT_W-1:0] cnt
);

   // A new issue outranks a retiring write to the same register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy <= 1'b0;
         cnt  <= '0;
      end else if (load) begin
         busy <= 1'b1;
         cnt  <= loadLat;
      end else if (clear) begin
         busy <= 1'b0;
         cnt  <= '0;
      end else if (cnt != '0) begin
         cnt <= cnt - LAT_W'(1);
      end
   end

endmodule

// File: rtl/scoreboard.sv
// Register scoreboard: tracks pending writes, raises RAW/WAW stall
// and bypass-ready flags. Ports: issue_*, flush, wb_* in;
// stall, fwd1_ready, fwd2_ready, busy_vec, pending_cnt out.
module scoreboard
   import scoreboard_pkg::*;
#(
   parameter  int NUM_REGS = DEF_NUM_REGS,
   parameter  int REG_SIZE = DEF_REG_SIZE,
   parameter  int MAX_LAT  = DEF_MAX_LAT,
   localparam int LAT_W    = $clog2(MAX_LAT + 1),
   localparam int CNT_W    = $clog2(NUM_REGS + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                issue_valid,
   input  logic                issue_we,
   input  logic [REG_SIZE-1:0] issue_rd,
   input  logic [LAT_W-1:0]    issue_lat,
   input  logic [REG_SIZE-1:0] issue_rs1,
   input  logic [REG_SIZE-1:0] issue_rs2,
   input  logic                flush,
   input  logic                wb_valid,
   input  logic [REG_SIZE-1:0] wb_rd,
   output logic                stall,
   output logic                fwd1_ready,
   output logic                fwd2_ready,
   output logic [NUM_REGS-1:0] busy_vec,
   output logic [CNT_W-1:0]    pending_cnt
);

   logic [NUM_REGS-1:0] busy;
   logic [LAT_W-1:0]    cnt [NUM_REGS];
   logic [LAT_W-1:0]    satLat;
   logic                raw1;
   logic                raw2;
   logic                waw;
   logic                hit1;
   logic                hit2;
   logic                accept;
   logic                writesRd;
   logic [CNT_W-1:0]    popSum;

   assign busy[0] = 1'b0;
   assign cnt[0]  = '0;

   assign satLat = (issue_lat > LAT_W'(MAX_LAT))
                 ? LAT_W'(MAX_LAT) : issue_lat;

   always_comb begin
      raw1 = 1'b0;
      raw2 = 1'b0;
      hit1 = 1'b0;
      hit2 = 1'b0;
      waw  = 1'b0;
      if (issue_rs1 != '0 && busy[issue_rs1]) begin
         raw1 = (cnt[issue_rs1] != '0);
         hit1 = (cnt[issue_rs1] == '0);
      end
      if (issue_rs2 != '0 && busy[issue_rs2]) begin
         raw2 = (cnt[issue_rs2] != '0);
         hit2 = (cnt[issue_rs2] == '0);
      end
      // An older write that lands no earlier than ours would
      // overwrite our result, so hold the younger one.
      if (issue_we && issue_rd != '0 && busy[issue_rd])
         waw = (cnt[issue_rd] >= satLat);
   end

   // Gating with reset keeps outputs quiet while state is cleared.
   assign stall = reset && issue_valid && !flush
                && (raw1 || raw2 || waw);
   assign fwd1_ready = reset && issue_valid && hit1;
   assign fwd2_ready = reset && issue_valid && hit2;

   assign accept   = issue_valid && !flush && !stall;
   assign writesRd = accept && issue_we && issue_rd != '0;

   for (genvar i = 1; i < NUM_REGS; i++) begin : gEntry
      sb_entry #(
         .LAT_W(LAT_W)
      ) uEntry (
         .clk    (clk),
         .reset  (reset),
         .load   (writesRd && issue_rd == REG_SIZE'(i)),
         .loadLat(satLat),
         .clear  (wb_valid && wb_rd == REG_SIZE'(i)),
         .busy   (busy[i]),
         .cnt    (cnt[i])
      );
   end

   always_comb begin
      popSum = '0;
      for (int i = 0; i < NUM_REGS; i++)
         popSum = popSum + CNT_W'(busy[i]);
   end

   assign busy_vec    = busy;
   assign pending_cnt = popSum;

endmodule

// File: tb/tb_scoreboard.sv
// Directed self-checking bench for the register scoreboard.
// Drives hand-built issue/writeback sequences and checks outputs.
module tb_scoreboard;

   logic        clk;
   logic        rst_n;
   logic        issue_valid;
   logic        issue_we;
   logic [4:0]  issue_rd;
   logic [2:0]  issue_lat;
   logic [4:0]  issue_rs1;
   logic [4:0]  issue_rs2;
   logic        flush;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic        stall;
   logic        fwd1_ready;
   logic        fwd2_ready;
   logic [31:0] busy_vec;
   logic [5:0]  pending_cnt;

   int vecs = 0;
   int errs = 0;

   scoreboard dut (
      .clk        (clk),
      .reset      (rst_n),
      .issue_valid(issue_valid),
      .issue_we   (issue_we),
      .issue_rd   (issue_rd),
      .issue_lat  (issue_lat),
      .issue_rs1  (issue_rs1),
      .issue_rs2  (issue_rs2),
      .flush      (flush),
      .wb_valid   (wb_valid),
      .wb_rd      (wb_rd),
      .stall      (stall),
      .fwd1_ready (fwd1_ready),
      .fwd2_ready (fwd2_ready),
      .busy_vec   (busy_vec),
      .pending_cnt(pending_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      issue_valid = 1'b0;
      issue_we    = 1'b0;
      issue_rd    = '0;
      issue_lat   = '0;
      issue_rs1   = '0;
      issue_rs2   = '0;
      flush       = 1'b0;
      wb_valid    = 1'b0;
      wb_rd       = '0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [4:0] rd, input logic [2:0] lat);
      idle();
      issue_valid = 1'b1;
      issue_we    = 1'b1;
      issue_rd    = rd;
      issue_lat   = lat;
   endtask

   task automatic rd1(input logic [4:0] rs);
      idle();
      issue_valid = 1'b1;
      issue_rs1   = rs;
   endtask

   task automatic wb(input logic [4:0] rd);
      idle();
      wb_valid = 1'b1;
      wb_rd    = rd;
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      issue_valid = 1'b1;
      issue_rs1   = 5'd5;
      #1;
      chk("rst_busy", 64'(busy_vec), 64'h0);
      chk("rst_pend", 64'(pending_cnt), 64'h0);
      chk("rst_stall", 64'(stall), 64'h0);
      chk("rst_fwd1", 64'(fwd1_ready), 64'h0);
      cyc();
      cyc();
      @(negedge clk);
      rst_n = 1'b1;

      // RAW on x5 with latency 2, first issue right after reset
      put(5'd5, 3'd2);
      #1;
      chk("raw_issue_stall", 64'(stall), 64'h0);
      cyc();
      rd1(5'd5);
      issue_rs2 = 5'd5;
      #1;
      chk("raw_busy", 64'(busy_vec), 64'h20);
      chk("raw_pend", 64'(pending_cnt), 64'h1);
      chk("raw_stall_c2", 64'(stall), 64'h1);
      chk("raw_fwd1_c2", 64'(fwd1_ready), 64'h0);
      cyc();
      chk("raw_stall_c1", 64'(stall), 64'h1);
      cyc();
      chk("raw_stall_c0", 64'(stall), 64'h0);
      chk("raw_fwd1", 64'(fwd1_ready), 64'h1);
      chk("raw_fwd2", 64'(fwd2_ready), 64'h1);
      wb(5'd5);
      cyc();
      idle();
      #1;
      chk("raw_wb_busy", 64'(busy_vec), 64'h0);

      // WAW on x7: older lat 3, younger lat 1
      put(5'd7, 3'd3);
      cyc();
      put(5'd7, 3'd1);
      #1;
      chk("waw_stall_c3", 64'(stall), 64'h1);
      cyc();
      chk("waw_stall_c2", 64'(stall), 64'h1);
      cyc();
      chk("waw_stall_c1", 64'(stall), 64'h1);
      cyc();
      chk("waw_stall_c0", 64'(stall), 64'h0);
      cyc();
      rd1(5'd7);
      #1;
      chk("waw_reload_stall", 64'(stall), 64'h1);
      cyc();
      chk("waw_reload_fwd", 64'(fwd1_ready), 64'h1);
      chk("waw_reload_nostall", 64'(stall), 64'h0);
      wb(5'd7);
      cyc();

      // same-cycle writeback and issue on x9
      put(5'd9, 3'd1);
      cyc();
      put(5'd9, 3'd4);
      wb_valid = 1'b1;
      wb_rd    = 5'd9;
      #1;
      chk("wbiss_stall", 64'(stall), 64'h0);
      cyc();
      rd1(5'd9);
      #1;
      chk("wbiss_busy", 64'(busy_vec), 64'h200);
      chk("wbiss_pend", 64'(pending_cnt), 64'h1);
      for (int i = 0; i < 4; i++) begin
         chk("wbiss_cnt_stall", 64'(stall), 64'h1);
         cyc();
      end
      chk("wbiss_cnt_done", 64'(stall), 64'h0);
      wb(5'd9);
      cyc();

      // writeback to idle register and to x0 is harmless
      wb(5'd12);
      cyc();
      wb(5'd0);
      cyc();
      idle();
      #1;
      chk("wb_idle_busy", 64'(busy_vec), 64'h0);

      // x0 never becomes busy
      put(5'd0, 3'd4);
      cyc();
      rd1(5'd0);
      #1;
      chk("x0_busy", 64'(busy_vec), 64'h0);
      chk("x0_stall", 64'(stall), 64'h0);
      chk("x0_fwd1", 64'(fwd1_ready), 64'h0);

      // latency saturation plus flush on x3
      put(5'd3, 3'd7);
      cyc();
      put(5'd10, 3'd2);
      issue_rs1 = 5'd3;
      flush     = 1'b1;
      #1;
      chk("flush_stall", 64'(stall), 64'h0);
      cyc();
      rd1(5'd3);
      #1;
      chk("flush_busy", 64'(busy_vec), 64'h8);
      chk("flush_pend", 64'(pending_cnt), 64'h1);
      for (int i = 0; i < 3; i++) begin
         chk("sat_stall", 64'(stall), 64'h1);
         cyc();
      end
      chk("sat_done", 64'(stall), 64'h0);
      chk("sat_fwd1", 64'(fwd1_ready), 64'h1);
      wb(5'd3);
      cyc();

      // asynchronous reset between edges
      put(5'd1, 3'd0);
      cyc();
      put(5'd2, 3'd1);
      cyc();
      put(5'd4, 3'd2);
      cyc();
      rd1(5'd1);
      issue_rs2 = 5'd4;
      #1;
      chk("pre_rst_busy", 64'(busy_vec), 64'h16);
      chk("pre_rst_pend", 64'(pending_cnt), 64'h3);
      chk("pre_rst_fwd1", 64'(fwd1_ready), 64'h1);
      chk("pre_rst_stall", 64'(stall), 64'h1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 64'(busy_vec), 64'h0);
      chk("mid_rst_pend", 64'(pending_cnt), 64'h0);
      chk("mid_rst_stall", 64'(stall), 64'h0);
      chk("mid_rst_fwd1", 64'(fwd1_ready), 64'h0);
      rst_n = 1'b1;
      wb(5'd2);
      cyc();
      put(5'd6, 3'd0);
      #1;
      chk("post_rst_stall", 64'(stall), 64'h0);
      cyc();
      idle();
      #1;
      chk("post_rst_busy", 64'(busy_vec), 64'h40);
      chk("post_rst_pend", 64'(pending_cnt), 64'h1);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
